// File: rtl/ahb_decoder_mux_pkg.sv
// Shared AHB-Lite codes and types for the decoder/mux slice.
package ahb_decoder_mux_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam int MAX_SLV = 8;

  typedef enum logic [1:0] {D_OKAY, D_ERR1, D_ERR2} dflt_state_e;

  // Data-phase owner: either the default slave or slot idx.
  typedef struct packed {
    logic       dflt;
    logic [2:0] idx;
  } dsel_t;

  localparam dsel_t DSEL_RST = '{dflt: 1'b1, idx: 3'd0};
endpackage

// File: rtl/ahb_decoder_mux_if.sv
// Bus bundle between the master side, the slave slots and the decoder/mux.
interface ahb_decoder_mux_if #(parameter int NUM_SLV = 8);
  logic [31:0]           HADDR;
  logic [1:0]            HTRANS;
  logic [NUM_SLV-1:0]    HSEL;
  logic [NUM_SLV-1:0]    s_HREADY;
  logic [2*NUM_SLV-1:0]  s_HRESP;
  logic [32*NUM_SLV-1:0] s_HRDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;
  logic [31:0]           HRDATA;
  logic [7:0]            err_cnt;

  modport master (
    output HADDR, HTRANS, s_HREADY, s_HRESP, s_HRDATA,
    input  HSEL, HREADY, HRESP, HRDATA, err_cnt
  );
  modport slave (
    input  HADDR, HTRANS, s_HREADY, s_HRESP, s_HRDATA,
    output HSEL, HREADY, HRESP, HRDATA, err_cnt
  );
endinterface

// File: rtl/ahb_decoder_mux_default_slave.sv
// Default slave: two-cycle ERROR for active transfers into unmapped space,
// plus a saturating count of those errors.
module ahb_default_slave
  import ahb_decoder_mux_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       sel,
  input  logic [1:0] HTRANS,
  output logic       ready,
  output logic [1:0] resp,
  output logic [7:0] err_cnt
);
  dflt_state_e state, nxt;
  logic unused_trans0;
  assign unused_trans0 = HTRANS[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= D_OKAY;
    else          state <= nxt;
  end

  always_comb begin
    nxt   = state;
    ready = 1'b1;
    resp  = HRESP_OKAY;
    case (state)
      D_OKAY: if (sel && HTRANS[1]) nxt = D_ERR1;
      D_ERR1: begin
        ready = 1'b0;
        resp  = HRESP_ERROR;
        nxt   = D_ERR2;
      end
      D_ERR2: begin
        resp = HRESP_ERROR;
        nxt  = (sel && HTRANS[1]) ? D_ERR1 : D_OKAY;
      end
      default: nxt = D_OKAY;
    endcase
  end

  // D_ERR1 always exits, so nxt==D_ERR1 marks exactly one entry per error.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                           err_cnt <= 8'h00;
    else if (nxt == D_ERR1 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
  end
endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and data-phase response mux with an internal
// default slave for unmapped or disabled slots.
module ahb_decoder_mux
  import ahb_decoder_mux_pkg::*;
#(
  parameter int         NUM_SLV = 8,
  parameter int         SEL_LSB = 16,
  parameter logic [7:0] SLV_EN  = 8'hFF
) (
  input  logic           HCLK,
  input  logic           HRESETn,
  ahb_decoder_mux_if.slave bus
);
  logic [2:0]  idx;
  logic        hit;
  dsel_t       dsel;
  logic        d_ready;
  logic [1:0]  d_resp;

  logic [MAX_SLV-1:0]       rdy_a;
  logic [MAX_SLV-1:0][1:0]  rsp_a;
  logic [MAX_SLV-1:0][31:0] dat_a;

  logic unused_addr;
  assign unused_addr = ^bus.HADDR[SEL_LSB-1:0];

  assign idx = bus.HADDR[SEL_LSB+2:SEL_LSB];
  assign hit = ((bus.HADDR >> (SEL_LSB + 3)) == 32'd0) &&
               (int'(idx) < NUM_SLV) && SLV_EN[idx];

  // Unpopulated array entries tie to 0 so the mux index never leaves range.
  for (genvar i = 0; i < MAX_SLV; i++) begin : g_slot
    if (i < NUM_SLV) begin : g_on
      assign bus.HSEL[i] = hit && (idx == 3'(i));
      assign rdy_a[i]    = bus.s_HREADY[i];
      assign rsp_a[i]    = bus.s_HRESP[2*i +: 2];
      assign dat_a[i]    = bus.s_HRDATA[32*i +: 32];
    end else begin : g_off
      assign rdy_a[i] = 1'b0;
      assign rsp_a[i] = 2'b00;
      assign dat_a[i] = 32'h0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)        dsel <= DSEL_RST;
    else if (bus.HREADY) dsel <= '{dflt: !hit, idx: idx};
  end

  always_comb begin
    bus.HREADY = d_ready;
    bus.HRESP  = d_resp;
    bus.HRDATA = 32'h0;
    if (!dsel.dflt) begin
      bus.HREADY = rdy_a[dsel.idx];
      bus.HRESP  = rsp_a[dsel.idx];
      bus.HRDATA = dat_a[dsel.idx];
    end
  end

  ahb_default_slave u_dflt (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .sel     (bus.HREADY && !hit),
    .HTRANS  (bus.HTRANS),
    .ready   (d_ready),
    .resp    (d_resp),
    .err_cnt (bus.err_cnt)
  );
endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Randomized bench: two decoders (all slots on / slot 6 off) against a
// transfer-level reference model.
module tb_ahb_decoder_mux;
  import ahb_decoder_mux_pkg::*;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  ahb_decoder_mux_if #(.NUM_SLV(8)) ifa ();
  ahb_decoder_mux_if #(.NUM_SLV(8)) ifb ();

  ahb_decoder_mux #(.NUM_SLV(8), .SEL_LSB(16), .SLV_EN(8'hFF)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(ifa));
  ahb_decoder_mux #(.NUM_SLV(8), .SEL_LSB(16), .SLV_EN(8'hBF)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(ifb));

  int n_chk = 0, n_err = 0;

  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        sr [8];
  logic [1:0]  sp [8];
  logic [31:0] sd [8];

  // Model: owner of the current data phase (-1 = default slave), error phase, count.
  logic [7:0] en [2] = '{8'hFF, 8'hBF};
  int m_cur [2];
  int m_err [2];
  int m_cnt [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int decode(logic [31:0] a, logic [7:0] e);
    int slot = int'(a >> 16);
    if (slot < 8 && e[slot]) return slot;
    return -1;
  endfunction

  function automatic logic exp_rdy(int d);
    return (m_cur[d] < 0) ? (m_err[d] != 1) : sr[m_cur[d]];
  endfunction
  function automatic logic [1:0] exp_resp(int d);
    return (m_cur[d] < 0) ? ((m_err[d] != 0) ? HRESP_ERROR : HRESP_OKAY) : sp[m_cur[d]];
  endfunction
  function automatic logic [31:0] exp_data(int d);
    return (m_cur[d] < 0) ? 32'h0 : sd[m_cur[d]];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = -1; m_err[d] = 0; m_cnt[d] = 0;
    end
  endtask

  task automatic apply();
    ifa.HADDR = haddr; ifb.HADDR = haddr;
    ifa.HTRANS = htrans; ifb.HTRANS = htrans;
    for (int i = 0; i < 8; i++) begin
      ifa.s_HREADY[i] = sr[i];        ifb.s_HREADY[i] = sr[i];
      ifa.s_HRESP[2*i +: 2] = sp[i];  ifb.s_HRESP[2*i +: 2] = sp[i];
      ifa.s_HRDATA[32*i +: 32] = sd[i]; ifb.s_HRDATA[32*i +: 32] = sd[i];
    end
  endtask

  // Called at the negedge with inputs stable: check, cross the edge, advance model.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      int t = decode(haddr, en[d]);
      logic [31:0] hs = (t < 0) ? 32'h0 : (32'h1 << t);
      check(d ? "b_hsel" : "a_hsel", d ? ifb.HSEL : ifa.HSEL, hs);
      check(d ? "b_hready" : "a_hready", d ? ifb.HREADY : ifa.HREADY, exp_rdy(d));
      check(d ? "b_hresp" : "a_hresp", d ? ifb.HRESP : ifa.HRESP, exp_resp(d));
      check(d ? "b_hrdata" : "a_hrdata", d ? ifb.HRDATA : ifa.HRDATA, exp_data(d));
      check(d ? "b_errcnt" : "a_errcnt", d ? ifb.err_cnt : ifa.err_cnt, m_cnt[d]);
    end
    @(posedge HCLK);
    for (int d = 0; d < 2; d++) begin
      if (exp_rdy(d)) begin
        m_cur[d] = decode(haddr, en[d]);
        if (m_cur[d] < 0 && htrans[1]) begin
          m_err[d] = 1;
          if (m_cnt[d] < 255) m_cnt[d]++;
        end else m_err[d] = 0;
      end else if (m_err[d] == 1) m_err[d] = 2;
    end
    #1;
  endtask

  task automatic tick();
    apply();
    @(negedge HCLK);
    step();
  endtask

  task automatic rnd();
    int k = $urandom_range(0, 9);
    if (k < 8)       haddr = {13'h0, 3'(k), 16'($urandom)};
    else if (k == 8) haddr = {13'($urandom_range(1, 8191)), 19'($urandom)};
    else             haddr = 32'h0008_0000 | 32'($urandom_range(0, 65535));
    htrans = 2'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++) begin
      sr[i] = ($urandom_range(0, 3) != 0);
      sp[i] = ($urandom_range(0, 7) == 0) ? HRESP_ERROR : HRESP_OKAY;
      sd[i] = $urandom;
    end
  endtask

  initial begin
    haddr = 32'hFFFF_0000; htrans = HTRANS_IDLE;
    for (int i = 0; i < 8; i++) begin
      sr[i] = 1'b1; sp[i] = HRESP_OKAY; sd[i] = 32'h1000_0000 + 32'(i);
    end
    HRESETn = 1'b0;
    model_reset();
    apply();
    #12;
    check("rst_hready", ifa.HREADY, 1'b1);
    check("rst_hresp", ifa.HRESP, HRESP_OKAY);
    check("rst_hrdata", ifa.HRDATA, 32'h0);
    check("rst_errcnt", ifa.err_cnt, 8'h00);
    check("rst_hsel", ifa.HSEL, 8'h00);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Decode to slot 6 (slot 6 disabled on dut_b -> ERROR there).
    sd[6] = 32'h1312_1110;
    haddr = 32'h0006_0010; htrans = HTRANS_NONSEQ;
    apply(); @(negedge HCLK);
    check("dec_hsel6", ifa.HSEL, 8'h40);
    check("dec_hsel6_dis", ifb.HSEL, 8'h00);
    step();
    haddr = 32'h0000_0000; htrans = HTRANS_IDLE;
    apply(); @(negedge HCLK);
    check("dec_rdata6", ifa.HRDATA, 32'h1312_1110);
    check("dis_err1_rdy", ifb.HREADY, 1'b0);
    check("dis_err1_resp", ifb.HRESP, HRESP_ERROR);
    step();

    // Slot 3 stalls two cycles while the address moves to slot 6.
    sd[3] = 32'h3333_0003;
    haddr = 32'h0003_0000; htrans = HTRANS_NONSEQ;
    tick();
    sr[3] = 1'b0; haddr = 32'h0006_0004;
    for (int c = 0; c < 2; c++) begin
      apply(); @(negedge HCLK);
      check("stall_rdata3", ifa.HRDATA, 32'h3333_0003);
      check("stall_rdy3", ifa.HREADY, 1'b0);
      step();
    end
    sr[3] = 1'b1;
    tick();
    htrans = HTRANS_IDLE;
    apply(); @(negedge HCLK);
    check("after_stall_rdata6", ifa.HRDATA, 32'h1312_1110);
    step();

    // Default slave two-cycle ERROR.
    haddr = 32'h0008_0000; htrans = HTRANS_NONSEQ;
    apply(); @(negedge HCLK);
    check("dflt_hsel", ifa.HSEL, 8'h00);
    step();
    htrans = HTRANS_IDLE;
    apply(); @(negedge HCLK);
    check("dflt_e1_rdy", ifa.HREADY, 1'b0);
    check("dflt_e1_resp", ifa.HRESP, HRESP_ERROR);
    step();
    apply(); @(negedge HCLK);
    check("dflt_e2_rdy", ifa.HREADY, 1'b1);
    check("dflt_e2_resp", ifa.HRESP, HRESP_ERROR);
    step();
    // IDLE to unmapped space is zero-wait OKAY.
    apply(); @(negedge HCLK);
    check("idle_rdy", ifa.HREADY, 1'b1);
    check("idle_resp", ifa.HRESP, HRESP_OKAY);
    step();

    // Random traffic with one mid-run reset.
    for (int c = 0; c < 400; c++) begin
      rnd();
      tick();
      if (c == 200) begin
        haddr = 32'h00F0_0000; htrans = HTRANS_IDLE; apply();
        HRESETn = 1'b0;
        #1;
        check("mrst_hready", ifa.HREADY, 1'b1);
        check("mrst_hresp", ifa.HRESP, HRESP_OKAY);
        check("mrst_hrdata", ifa.HRDATA, 32'h0);
        check("mrst_errcnt", ifa.err_cnt, 8'h00);
        check("mrst_hsel", ifa.HSEL, 8'h00);
        model_reset();
        #1 HRESETn = 1'b1;
      end
    end

    // Saturation: 300 back-to-back unmapped NONSEQ.
    for (int i = 0; i < 8; i++) sr[i] = 1'b1;
    haddr = 32'h0100_0000; htrans = HTRANS_NONSEQ;
    for (int c = 0; c < 600; c++) tick();
    check("sat_a", ifa.err_cnt, 8'hFF);
    check("sat_b", ifb.err_cnt, 8'hFF);

    // Slave-generated ERROR passes straight through.
    htrans = HTRANS_IDLE; tick(); tick();
    haddr = 32'h0002_0000; htrans = HTRANS_NONSEQ; tick();
    sr[2] = 1'b0; sp[2] = HRESP_ERROR; htrans = HTRANS_IDLE;
    apply(); @(negedge HCLK);
    check("serr1_rdy", ifa.HREADY, 1'b0);
    check("serr1_resp", ifa.HRESP, HRESP_ERROR);
    step();
    sr[2] = 1'b1;
    apply(); @(negedge HCLK);
    check("serr2_rdy", ifa.HREADY, 1'b1);
    check("serr2_resp", ifa.HRESP, HRESP_ERROR);
    step();
    sp[2] = HRESP_OKAY;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
